// File: rtl/fetch_decode_if.sv
// Instruction-memory and decode-register bus between fetch_decode and its neighbours.
// The master side is fetch_decode; the slave side is instruction memory plus the ALU.
interface fetch_decode_if #(
   parameter int PC_W = 8
);
   logic [PC_W-1:0] imem_addr;
   logic [8:0]      imem_data;
   logic            branch;
   logic            type_code;
   logic [3:0]      r_op;
   logic [2:0]      i_op;
   logic [4:0]      imm;
   logic [3:0]      reg_sel;
   logic            dec_valid;
   logic [PC_W-1:0] dec_pc;

   modport master (
      output imem_addr,
      input  imem_data,
      input  branch,
      output type_code, r_op, i_op, imm, reg_sel,
      output dec_valid, dec_pc
   );

   modport slave (
      input  imem_addr,
      output imem_data,
      output branch,
      input  type_code, r_op, i_op, imm, reg_sel,
      input  dec_valid, dec_pc
   );
endinterface

// File: rtl/fetch_decode.sv
// Fetch/decode stage of the 8-bit accumulator CPU: PC, decode register,
// branch-target LUT redirect and HALT detection.
module fetch_decode #(
   parameter int PC_W      = 8,
   parameter int LUT_DEPTH = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                stall,
   input  logic                lut_we,
   input  logic [3:0]          lut_waddr,
   input  logic [PC_W-1:0]     lut_wdata,
   output logic                busy,
   output logic                done,
   fetch_decode_if.master      bus
);
   typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

   state_t          state;
   logic [PC_W-1:0] pc;
   logic [PC_W-1:0] decPc;
   logic [8:0]      decInstr;
   logic            decValid;
   logic [PC_W-1:0] lutMem [LUT_DEPTH];
   logic            isHalt;

   assign isHalt = decValid && decInstr[8] && (decInstr[7:5] == 3'b111);

   assign bus.imem_addr = pc;
   assign bus.type_code = decInstr[8];
   assign bus.r_op      = decInstr[7:4];
   assign bus.i_op      = decInstr[7:5];
   assign bus.imm       = decInstr[4:0];
   assign bus.reg_sel   = decInstr[3:0];
   assign bus.dec_valid = decValid;
   assign bus.dec_pc    = decPc;

   // Nonblocking write means a same-cycle branch read sees the old target.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < LUT_DEPTH; i++) lutMem[i] <= '0;
      end else if (lut_we) begin
         lutMem[lut_waddr] <= lut_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         pc       <= '0;
         decPc    <= '0;
         decInstr <= '0;
         decValid <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else if (!stall) begin
         case (state)
            IDLE, HALT: begin
               if (start) begin
                  state    <= RUN;
                  pc       <= '0;
                  decValid <= 1'b0;
                  busy     <= 1'b1;
                  done     <= 1'b0;
               end
            end
            RUN: begin
               if (bus.branch && decValid) begin
                  // Redirect and squash the fall-through fetch: one bubble.
                  pc       <= lutMem[decInstr[3:0]];
                  decValid <= 1'b0;
               end else if (isHalt) begin
                  state    <= HALT;
                  decValid <= 1'b0;
                  busy     <= 1'b0;
                  done     <= 1'b1;
               end else begin
                  decInstr <= bus.imem_data;
                  decPc    <= pc;
                  decValid <= 1'b1;
                  pc       <= pc + PC_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fetch_decode.sv
// Self-checking bench for fetch_decode: directed scenarios then randomized traffic,
// all compared each cycle against a behavioural model of the stage.
module tb_fetch_decode;
   localparam int PC_W = 8;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            start = 1'b0;
   logic            stall = 1'b0;
   logic            lut_we = 1'b0;
   logic [3:0]      lut_waddr = '0;
   logic [PC_W-1:0] lut_wdata = '0;
   logic            busy;
   logic            done;
   logic [8:0]      imem [256];

   fetch_decode_if #(.PC_W(PC_W)) bus ();

   assign bus.imem_data = imem[bus.imem_addr];

   always #5 clk = ~clk;

   fetch_decode #(.PC_W(PC_W), .LUT_DEPTH(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .stall     (stall),
      .lut_we    (lut_we),
      .lut_waddr (lut_waddr),
      .lut_wdata (lut_wdata),
      .busy      (busy),
      .done      (done),
      .bus       (bus)
   );

   int checks = 0;
   int errors = 0;

   // Model: mode 0 idle, 1 running, 2 halted.
   int              mMode;
   logic [7:0]      mPc;
   logic [7:0]      mDecPc;
   logic [8:0]      mInstr;
   bit              mValid;
   logic [7:0]      mLut [16];

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic modelReset();
      mMode  = 0;
      mPc    = 8'h00;
      mDecPc = 8'h00;
      mInstr = 9'h000;
      mValid = 1'b0;
      for (int i = 0; i < 16; i++) mLut[i] = 8'h00;
   endtask

   // One clock of architectural behaviour, evaluated with the inputs now applied.
   task automatic stepModel();
      bit haltHeld;
      haltHeld = mValid && (mInstr[8] == 1'b1) && (mInstr[7:5] == 3'b111);
      if (!stall) begin
         if (mMode != 1) begin
            if (start) begin
               mMode  = 1;
               mPc    = 8'h00;
               mValid = 1'b0;
            end
         end else if (bus.branch && mValid) begin
            mPc    = mLut[mInstr[3:0]];
            mValid = 1'b0;
         end else if (haltHeld) begin
            mMode  = 2;
            mValid = 1'b0;
         end else begin
            mInstr = imem[mPc];
            mDecPc = mPc;
            mValid = 1'b1;
            mPc    = mPc + 8'd1;
         end
      end
      if (lut_we) mLut[lut_waddr] = lut_wdata;
   endtask

   task automatic compareAll();
      checkVal("imem_addr", 32'(bus.imem_addr), 32'(mPc));
      checkVal("dec_valid", 32'(bus.dec_valid), 32'(mValid));
      checkVal("dec_pc",    32'(bus.dec_pc),    32'(mDecPc));
      checkVal("type_code", 32'(bus.type_code), 32'(mInstr[8]));
      checkVal("r_op",      32'(bus.r_op),      32'(mInstr[7:4]));
      checkVal("i_op",      32'(bus.i_op),      32'(mInstr[7:5]));
      checkVal("imm",       32'(bus.imm),       32'(mInstr[4:0]));
      checkVal("reg_sel",   32'(bus.reg_sel),   32'(mInstr[3:0]));
      checkVal("busy",      32'(busy),          32'(mMode == 1));
      checkVal("done",      32'(done),          32'(mMode == 2));
   endtask

   // Called at a falling edge: apply inputs, advance model, wait one clock, compare.
   task automatic cycle(input bit st, input bit sl, input bit br, input bit we,
                        input logic [3:0] wa, input logic [7:0] wd);
      start      = st;
      stall      = sl;
      bus.branch = br;
      lut_we     = we;
      lut_waddr  = wa;
      lut_wdata  = wd;
      stepModel();
      @(posedge clk);
      @(negedge clk);
      compareAll();
   endtask

   // Pulse rst_n between edges and check outputs clear before the next rising edge.
   task automatic asyncReset();
      #2 rst_n = 1'b0;
      #1;
      checkVal("rst_addr",  32'(bus.imem_addr), 32'h0);
      checkVal("rst_valid", 32'(bus.dec_valid), 32'h0);
      checkVal("rst_decpc", 32'(bus.dec_pc),    32'h0);
      checkVal("rst_fields", 32'({bus.type_code, bus.r_op, bus.imm}), 32'h0);
      checkVal("rst_busy",  32'(busy),          32'h0);
      checkVal("rst_done",  32'(done),          32'h0);
      modelReset();
      #1 rst_n = 1'b1;
   endtask

   initial begin
      bit seenWrap;
      logic [7:0] prevAddr;
      for (int i = 0; i < 256; i++) imem[i] = 9'h000;
      bus.branch = 1'b0;
      modelReset();
      @(negedge clk);
      compareAll();
      rst_n = 1'b1;

      // Sequential run ending in HALT at address 3.
      imem[0] = 9'h103; imem[1] = 9'h101; imem[2] = 9'h000; imem[3] = 9'h1E0;
      cycle(1, 0, 0, 0, 4'd0, 8'h00);
      checkVal("seq_addr0", 32'(bus.imem_addr), 32'h0);
      checkVal("seq_valid0", 32'(bus.dec_valid), 32'h0);
      for (int k = 1; k <= 4; k++) begin
         cycle(0, 0, 0, 0, 4'd0, 8'h00);
         checkVal("seq_addr", 32'(bus.imem_addr), 32'(k));
         checkVal("seq_valid", 32'(bus.dec_valid), 32'h1);
      end
      checkVal("seq_done_early", 32'(done), 32'h0);
      cycle(0, 0, 0, 0, 4'd0, 8'h00);
      checkVal("seq_done", 32'(done), 32'h1);
      checkVal("seq_busy", 32'(busy), 32'h0);
      cycle(0, 0, 0, 0, 4'd0, 8'h00);
      checkVal("seq_pc_hold", 32'(bus.imem_addr), 32'h4);
      $display("scenario seq_halt checks=%0d", checks);

      // Taken branch with a 3-cycle stall holding branch high.
      imem[3] = 9'h000; imem[2] = 9'h0D5; imem[8'h20] = 9'h0AB;
      cycle(0, 0, 0, 1, 4'd5, 8'h20);
      cycle(1, 0, 0, 0, 4'd0, 8'h00);
      for (int k = 0; k < 3; k++) cycle(0, 0, 0, 0, 4'd0, 8'h00);
      checkVal("br_decpc", 32'(bus.dec_pc), 32'h2);
      for (int k = 0; k < 3; k++) begin
         cycle(0, 1, 1, 0, 4'd0, 8'h00);
         checkVal("stall_addr", 32'(bus.imem_addr), 32'h3);
         checkVal("stall_decpc", 32'(bus.dec_pc), 32'h2);
         checkVal("stall_valid", 32'(bus.dec_valid), 32'h1);
      end
      cycle(0, 0, 1, 0, 4'd0, 8'h00);
      checkVal("br_target", 32'(bus.imem_addr), 32'h20);
      checkVal("br_bubble", 32'(bus.dec_valid), 32'h0);
      cycle(0, 0, 0, 0, 4'd0, 8'h00);
      checkVal("br_tgt_pc", 32'(bus.dec_pc), 32'h20);
      checkVal("br_tgt_rop", 32'(bus.r_op), 32'hA);
      checkVal("br_tgt_imm", 32'(bus.imm), 32'h0B);
      $display("scenario branch_stall checks=%0d", checks);

      // Reset mid-run clears the LUT: branch through reg 5 lands at 0.
      asyncReset();
      cycle(1, 0, 0, 0, 4'd0, 8'h00);
      for (int k = 0; k < 3; k++) cycle(0, 0, 0, 0, 4'd0, 8'h00);
      cycle(0, 0, 1, 0, 4'd0, 8'h00);
      checkVal("rst_lut", 32'(bus.imem_addr), 32'h0);
      $display("scenario reset_lut checks=%0d", checks);

      // Write collision: branch uses old LUT[5], a later branch the new one.
      asyncReset();
      imem[8'h20] = 9'h0D5;
      cycle(0, 0, 0, 1, 4'd5, 8'h20);
      cycle(1, 0, 0, 0, 4'd0, 8'h00);
      for (int k = 0; k < 3; k++) cycle(0, 0, 0, 0, 4'd0, 8'h00);
      cycle(0, 0, 1, 1, 4'd5, 8'h40);
      checkVal("col_old", 32'(bus.imem_addr), 32'h20);
      cycle(0, 0, 0, 0, 4'd0, 8'h00);
      cycle(0, 0, 1, 0, 4'd0, 8'h00);
      checkVal("col_new", 32'(bus.imem_addr), 32'h40);
      $display("scenario lut_collision checks=%0d", checks);

      // PC wrap with an all-zero program.
      asyncReset();
      for (int i = 0; i < 256; i++) imem[i] = 9'h000;
      cycle(1, 0, 0, 0, 4'd0, 8'h00);
      seenWrap = 1'b0;
      for (int k = 0; k < 300; k++) begin
         prevAddr = bus.imem_addr;
         cycle(0, 0, 0, 0, 4'd0, 8'h00);
         if (prevAddr == 8'hFF) begin
            seenWrap = 1'b1;
            checkVal("wrap_addr", 32'(bus.imem_addr), 32'h0);
         end
         checkVal("wrap_busy", 32'(busy), 32'h1);
      end
      checkVal("wrap_seen", 32'(seenWrap), 32'h1);
      $display("scenario pc_wrap checks=%0d", checks);

      // Randomized traffic.
      for (int i = 0; i < 256; i++) begin
         imem[i] = 9'($urandom);
         if (imem[i][8] && imem[i][7:5] == 3'b111 && ($urandom_range(3) != 0)) imem[i][8] = 1'b0;
      end
      asyncReset();
      for (int k = 0; k < 2000; k++) begin
         if ($urandom_range(499) == 0) asyncReset();
         cycle($urandom_range(19) == 0, $urandom_range(4) == 0, $urandom_range(3) == 0,
               $urandom_range(3) == 0, 4'($urandom), 8'($urandom));
      end
      $display("scenario random checks=%0d", checks);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
